// File: rtl/cam_pkg.sv
// Shared types and constants for the OV camera controller: sequencer states,
// table terminator, SCCB ack encodings and small elaboration helpers.
package cam_pkg;

    typedef enum logic [3:0] {
        StBoot,
        StFetch,
        StStart,
        StAddr,
        StData,
        StStopw,
        StGap,
        StSettle,
        StError,
        StArm,
        StFrame
    } cam_state_e;

    localparam logic [15:0] CFG_END = 16'hFFFF;
    localparam logic [1:0]  ACK     = 2'b11;
    localparam logic [1:0]  NACK    = 2'b10;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A wait of lim cycles ends on the cycle where cnt reaches lim-1 (lim=0 behaves as 1).
    function automatic logic dly_done(input logic [31:0] cnt, input int unsigned lim);
        return (cnt + 32'd1) >= lim;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser for an asynchronous camera pin, followed by an
// edge-detect register producing single-cycle rise/fall strobes.
module cam_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[1:0], din};
        end
    end

    assign level = sr_q[1];
    assign rise  = sr_q[1] & ~sr_q[2];
    assign fall  = ~sr_q[1] & sr_q[2];

endmodule

// File: rtl/ov_cam_ctrl.sv
// OV camera controller: table-driven SCCB register sequencer with NACK retry,
// then a frame-gated pixel capture path feeding a downstream FIFO.
module ov_cam_ctrl
    import cam_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR      = 8'h42,
    parameter int unsigned N_CFG         = 64,
    parameter int unsigned BOOT_DLY      = 2**26,
    parameter int unsigned GAP_DLY       = 2**16,
    parameter int unsigned SETTLE_DLY    = 2**26,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned BYTES_PER_PIX = 2,
    localparam int unsigned PIX_W        = 8 * BYTES_PER_PIX,
    localparam int unsigned IDX_W        = $clog2(N_CFG)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] cfg_idx,
    input  logic [15:0]      cfg_entry,
    output logic             sccb_start,
    output logic             sccb_stop,
    output logic [7:0]       sccb_wr_data,
    input  logic [1:0]       sccb_ack,
    input  logic             cmos_pclk,
    input  logic             cmos_href,
    input  logic             cmos_vsync,
    input  logic [7:0]       cmos_d,
    input  logic             capture_en,
    input  logic             pix_full,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_sof,
    output logic             line_end,
    output logic             frame_end,
    output logic [15:0]      frame_cnt,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic             pix_ovf
);

    localparam int unsigned DLY_W = $clog2(max3(BOOT_DLY, GAP_DLY, SETTLE_DLY) + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);
    localparam int unsigned BC_W  = $clog2(BYTES_PER_PIX + 1);

    cam_state_e       state_q, state_d;
    logic [DLY_W-1:0] dly_q;
    logic [IDX_W:0]   idx_q;
    logic [RTY_W-1:0] retry_q;

    logic pclk_lvl, pclk_rise, pclk_fall;
    logic href_lvl, href_rise, href_fall;
    logic vsync_lvl, vsync_rise, vsync_fall;

    logic ack_ok, ack_nack, in_wait, retry_over, idx_end, arm_go;

    assign ack_ok     = (sccb_ack == ACK);
    assign ack_nack   = (sccb_ack == NACK);
    assign in_wait    = state_q inside {StAddr, StData, StStopw};
    assign retry_over = (32'(retry_q) + 32'd1) > MAX_RETRY;
    assign idx_end    = (32'(idx_q) == N_CFG);
    assign arm_go     = (state_q == StArm) && vsync_fall && capture_en;

    // ---------------- Sequencer FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:   if (dly_done(32'(dly_q), BOOT_DLY)) state_d = StFetch;
            StFetch:  state_d = (cfg_entry == CFG_END || idx_end) ? StSettle : StStart;
            StStart:  state_d = StAddr;
            StAddr: begin
                if (ack_ok)        state_d = StData;
                else if (ack_nack) state_d = retry_over ? StError : StGap;
            end
            StData: begin
                if (ack_ok)        state_d = StStopw;
                else if (ack_nack) state_d = retry_over ? StError : StGap;
            end
            StStopw: begin
                if (ack_ok)        state_d = StGap;
                else if (ack_nack) state_d = retry_over ? StError : StGap;
            end
            StGap:    if (dly_done(32'(dly_q), GAP_DLY)) state_d = StFetch;
            StSettle: if (dly_done(32'(dly_q), SETTLE_DLY)) state_d = StArm;
            StError:  state_d = StError;
            StArm:    if (arm_go) state_d = StFrame;
            StFrame:  if (vsync_rise) state_d = StArm;
            default:  state_d = StBoot;
        endcase
    end

    always_comb begin
        sccb_start   = 1'b0;
        sccb_stop    = 1'b0;
        sccb_wr_data = '0;
        unique case (state_q)
            StStart: begin
                sccb_start   = 1'b1;
                sccb_wr_data = DEV_ADDR;
            end
            StAddr:  if (ack_ok) sccb_wr_data = cfg_entry[15:8];
            StData:  if (ack_ok) sccb_wr_data = cfg_entry[7:0];
            StStopw: if (ack_ok) sccb_stop = 1'b1;
            default: ;
        endcase
        if (in_wait && ack_nack) sccb_stop = 1'b1;
    end

    assign cfg_done = state_q inside {StArm, StFrame};
    assign cfg_err  = (state_q == StError);
    assign cfg_idx  = idx_q[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q   <= '0;
            idx_q   <= '0;
            retry_q <= '0;
        end else begin
            if (state_d != state_q) begin
                dly_q <= '0;
            end else if (state_q inside {StBoot, StGap, StSettle}) begin
                dly_q <= dly_q + 1'b1;
            end
            if (state_q == StStopw && ack_ok) begin
                idx_q   <= idx_q + 1'b1;
                retry_q <= '0;
            end else if (in_wait && ack_nack) begin
                retry_q <= retry_q + 1'b1;
            end
        end
    end

    // ---------------- Capture path ----------------
    cam_sync_edge u_sync_pclk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cmos_pclk),
        .level (pclk_lvl),
        .rise  (pclk_rise),
        .fall  (pclk_fall)
    );

    cam_sync_edge u_sync_href (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cmos_href),
        .level (href_lvl),
        .rise  (href_rise),
        .fall  (href_fall)
    );

    cam_sync_edge u_sync_vsync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cmos_vsync),
        .level (vsync_lvl),
        .rise  (vsync_rise),
        .fall  (vsync_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{pclk_lvl, pclk_fall, href_rise, vsync_lvl};

    // Three data stages keep the byte aligned with the detected pclk edge.
    logic [7:0]       d1_q, d2_q, d3_q;
    logic [BC_W-1:0]  bcnt_q;
    logic [PIX_W-1:0] shreg_q, shreg_next;
    logic [PIX_W+7:0] shift_wide;
    logic             first_q, in_frame, take_byte, pix_done;
    logic             pix_valid_q, pix_sof_q, line_end_q, frame_end_q, pix_ovf_q;
    logic [PIX_W-1:0] pix_data_q;
    logic [15:0]      frame_cnt_q;

    assign in_frame   = (state_q == StFrame);
    assign take_byte  = in_frame && pclk_rise && href_lvl;
    assign pix_done   = take_byte && ((32'(bcnt_q) + 32'd1) == BYTES_PER_PIX);
    assign shift_wide = {shreg_q, d3_q};
    assign shreg_next = shift_wide[PIX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_q        <= '0;
            d2_q        <= '0;
            d3_q        <= '0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            first_q     <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_sof_q   <= 1'b0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
            frame_cnt_q <= '0;
            pix_ovf_q   <= 1'b0;
        end else begin
            d1_q        <= cmos_d;
            d2_q        <= d1_q;
            d3_q        <= d2_q;
            pix_valid_q <= 1'b0;
            pix_sof_q   <= 1'b0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
            if (arm_go) begin
                first_q <= 1'b1;
                bcnt_q  <= '0;
            end
            if (take_byte) begin
                shreg_q <= shreg_next;
                if (pix_done) begin
                    bcnt_q  <= '0;
                    first_q <= 1'b0;
                    if (!pix_full) begin
                        pix_valid_q <= 1'b1;
                        pix_data_q  <= shreg_next;
                        pix_sof_q   <= first_q;
                    end else begin
                        pix_ovf_q <= 1'b1;
                    end
                end else begin
                    bcnt_q <= bcnt_q + 1'b1;
                end
            end
            // Later assignments win: line/frame boundaries discard any partial pixel.
            if (in_frame && href_fall) begin
                line_end_q <= 1'b1;
                bcnt_q     <= '0;
            end
            if (in_frame && vsync_rise) begin
                frame_end_q <= 1'b1;
                frame_cnt_q <= frame_cnt_q + 1'b1;
                bcnt_q      <= '0;
            end
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_sof   = pix_sof_q;
    assign line_end  = line_end_q;
    assign frame_end = frame_end_q;
    assign frame_cnt = frame_cnt_q;
    assign pix_ovf   = pix_ovf_q;

endmodule

// File: tb/tb_ov_cam_ctrl.sv
// Scoreboard bench for ov_cam_ctrl: an SCCB engine model and a pixel monitor
// pop expected transactions/pixels pushed by the directed stimulus.
module tb_ov_cam_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  cfg_idx;
    logic [15:0] cfg_entry;
    logic        sccb_start, sccb_stop;
    logic [7:0]  sccb_wr_data;
    logic [1:0]  sccb_ack;
    logic        cmos_pclk, cmos_href, cmos_vsync;
    logic [7:0]  cmos_d;
    logic        capture_en, pix_full;
    logic        pix_valid, pix_sof, line_end, frame_end;
    logic [15:0] pix_data, frame_cnt;
    logic        cfg_done, cfg_err, pix_ovf;

    logic [15:0] rom [8];
    assign cfg_entry = rom[cfg_idx];

    ov_cam_ctrl #(
        .DEV_ADDR      (8'h42),
        .N_CFG         (8),
        .BOOT_DLY      (100),
        .GAP_DLY       (8),
        .SETTLE_DLY    (20),
        .MAX_RETRY     (3),
        .BYTES_PER_PIX (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_idx      (cfg_idx),
        .cfg_entry    (cfg_entry),
        .sccb_start   (sccb_start),
        .sccb_stop    (sccb_stop),
        .sccb_wr_data (sccb_wr_data),
        .sccb_ack     (sccb_ack),
        .cmos_pclk    (cmos_pclk),
        .cmos_href    (cmos_href),
        .cmos_vsync   (cmos_vsync),
        .cmos_d       (cmos_d),
        .capture_en   (capture_en),
        .pix_full     (pix_full),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_sof      (pix_sof),
        .line_end     (line_end),
        .frame_end    (frame_end),
        .frame_cnt    (frame_cnt),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .pix_ovf      (pix_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc;
    int start_cnt = 0;
    int first_start_cyc = 0;
    int nack_slot = -1;
    int nack_left = 0;
    bit all_nack = 1'b0;
    int le_cnt = 0;
    int fe_cnt = 0;

    // {stop at end, stop too early, byte0, byte1, byte2}
    logic [25:0] exp_sccb [$];
    // {sof, data}
    logic [16:0] exp_pix [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // SCCB byte engine model: acks each byte a few cycles after it is issued.
    initial begin
        logic [7:0]  b [3];
        logic        stop_end, early, ab;
        logic [25:0] tok;
        sccb_ack = 2'b00;
        forever begin
            @(negedge clk);
            if (rst_n && sccb_start) begin
                if (start_cnt == 0) first_start_cyc = cyc;
                start_cnt++;
                b[0] = sccb_wr_data;
                b[1] = 8'h00;
                b[2] = 8'h00;
                stop_end = 1'b0;
                early = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    repeat (3) @(negedge clk);
                    ab = 1'b1;
                    if (all_nack) begin
                        ab = 1'b0;
                    end else if (s == nack_slot && nack_left > 0) begin
                        ab = 1'b0;
                        nack_left--;
                    end
                    sccb_ack = {1'b1, ab};
                    #1;
                    if (ab && s < 2) b[s+1] = sccb_wr_data;
                    if (!ab || s == 2) stop_end = sccb_stop;
                    else               early = early | sccb_stop;
                    @(negedge clk);
                    sccb_ack = 2'b00;
                    if (!ab) break;
                end
                tok = {stop_end, early, b[0], b[1], b[2]};
                if (exp_sccb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sccb_txn actual %0h required none", tok);
                end else begin
                    chk("sccb_txn", tok, exp_sccb.pop_front());
                end
            end
        end
    end

    // Pixel monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid) begin
                if (exp_pix.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix actual %0h required none", {pix_sof, pix_data});
                end else begin
                    chk("pix", {pix_sof, pix_data}, exp_pix.pop_front());
                end
            end
            if (line_end)  le_cnt++;
            if (frame_end) fe_cnt++;
        end
    end

    task automatic cam_byte(input logic [7:0] b);
        cmos_d = b;
        #40 cmos_pclk = 1'b1;
        #40 cmos_pclk = 1'b0;
    endtask

    task automatic cam_line(input logic [31:0] v, input int n);
        cmos_href = 1'b1;
        #40;
        for (int i = 0; i < n; i++) cam_byte(v[31-8*i -: 8]);
        #40 cmos_href = 1'b0;
        #80;
    endtask

    task automatic frame_start();
        cmos_vsync = 1'b1;
        #80 cmos_vsync = 1'b0;
        #80;
    endtask

    task automatic frame_stop();
        cmos_vsync = 1'b1;
        #80;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!cfg_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, cfg_done, 1);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk(name, {sccb_start, sccb_stop, sccb_wr_data, cfg_idx, pix_valid, pix_data, pix_sof,
                   line_end, frame_end, frame_cnt, cfg_done, cfg_err, pix_ovf}, 64'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int n;
        rom[0] = 16'h1280;
        rom[1] = 16'h1204;
        for (int i = 2; i < 8; i++) rom[i] = 16'hFFFF;
        capture_en = 1'b1;
        pix_full   = 1'b0;
        cmos_pclk  = 1'b0;
        cmos_href  = 1'b0;
        cmos_vsync = 1'b0;
        cmos_d     = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        chk_zero_outputs("reset_outputs");

        // Boot and configuration, all ACK.
        exp_sccb.push_back({1'b1, 1'b0, 24'h421280});
        exp_sccb.push_back({1'b1, 1'b0, 24'h421204});
        @(negedge clk) rst_n = 1'b1;
        wait_done("cfg_done_rise");
        chk("first_start_cyc", first_start_cyc, 101);
        chk("cfg_idx_done", cfg_idx, 2);
        chk("start_cnt_cfg", start_cnt, 2);
        chk("sccb_q_empty_cfg", exp_sccb.size(), 0);
        chk("cfg_err_clean", cfg_err, 0);

        // Capture: two lines of AA BB CC DD.
        exp_pix.push_back({1'b1, 16'hAABB});
        exp_pix.push_back({1'b0, 16'hCCDD});
        exp_pix.push_back({1'b0, 16'hAABB});
        exp_pix.push_back({1'b0, 16'hCCDD});
        frame_start();
        cam_line(32'hAABBCCDD, 4);
        cam_line(32'hAABBCCDD, 4);
        frame_stop();
        chk("pix_q_empty_cap", exp_pix.size(), 0);
        chk("line_end_cnt_cap", le_cnt, 2);
        chk("frame_end_cnt_cap", fe_cnt, 1);
        chk("frame_cnt_cap", frame_cnt, 1);
        chk("pix_ovf_clean", pix_ovf, 0);

        // Overflow on second pixel, then a 3-byte line, then an aligned line.
        exp_pix.push_back({1'b1, 16'hAABB});
        exp_pix.push_back({1'b0, 16'h1122});
        exp_pix.push_back({1'b0, 16'h4455});
        frame_start();
        cmos_href = 1'b1;
        #40;
        cam_byte(8'hAA);
        cam_byte(8'hBB);
        cam_byte(8'hCC);
        pix_full = 1'b1;
        cam_byte(8'hDD);
        #40 cmos_href = 1'b0;
        #40 pix_full = 1'b0;
        #40;
        cam_line(32'h11223300, 3);
        cam_line(32'h44550000, 2);
        frame_stop();
        chk("pix_q_empty_ovf", exp_pix.size(), 0);
        chk("pix_ovf_set", pix_ovf, 1);
        chk("frame_cnt_ovf", frame_cnt, 2);
        chk("line_end_cnt_ovf", le_cnt, 5);

        // Frame skipped when capture_en is low at vsync fall.
        capture_en = 1'b0;
        frame_start();
        cam_line(32'hAABBCCDD, 4);
        capture_en = 1'b1;
        frame_stop();
        chk("frame_cnt_skip", frame_cnt, 2);
        chk("line_end_cnt_skip", le_cnt, 5);
        chk("frame_end_cnt_skip", fe_cnt, 2);

        // Reset mid-frame, then reconfigure with one NACK on the second byte.
        exp_pix.push_back({1'b1, 16'hAABB});
        frame_start();
        cmos_href = 1'b1;
        #40;
        cam_byte(8'hAA);
        cam_byte(8'hBB);
        cam_byte(8'hCC);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midframe_reset_outputs");
        cmos_href = 1'b0;
        cmos_d = 8'h00;
        chk("pix_q_empty_midframe", exp_pix.size(), 0);
        start_cnt = 0;
        nack_slot = 1;
        nack_left = 1;
        exp_sccb.push_back({1'b1, 1'b0, 24'h421200});
        exp_sccb.push_back({1'b1, 1'b0, 24'h421280});
        exp_sccb.push_back({1'b1, 1'b0, 24'h421204});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done("cfg_done_retry");
        chk("first_start_after_reset", first_start_cyc, 101);
        chk("start_cnt_retry", start_cnt, 3);
        chk("cfg_idx_retry", cfg_idx, 2);
        chk("sccb_q_empty_retry", exp_sccb.size(), 0);

        // All NACK: four attempts then terminal error.
        rst_n = 1'b0;
        all_nack = 1'b1;
        start_cnt = 0;
        for (int i = 0; i < 4; i++) exp_sccb.push_back({1'b1, 1'b0, 24'h420000});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!cfg_err && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (100) @(negedge clk);
        chk("cfg_err_set", cfg_err, 1);
        chk("start_cnt_err", start_cnt, 4);
        chk("cfg_done_err", cfg_done, 0);
        chk("cfg_idx_err", cfg_idx, 0);
        chk("sccb_q_empty_err", exp_sccb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ov_cam_ctrl.md
# ov_cam_ctrl

Parametrised OV-series camera controller: a table-driven SCCB register sequencer with NACK retry, followed by a frame-gated pixel capture path. It sits between an external SCCB byte engine (start/stop/wr_data/ack handshake), a configuration ROM, and a downstream pixel FIFO. Camera pins are sampled in the `clk` domain, where `clk` is at least 4x `cmos_pclk`.

## Interface
- `DEV_ADDR`, 8'h42: SCCB write slave address.
- `N_CFG`, 64: maximum table entries. `cfg_idx` width is `$clog2(N_CFG)`.
- `BOOT_DLY`, 2**26: clk cycles from reset release to the first transaction.
- `GAP_DLY`, 2**16: idle clk cycles between transactions.
- `SETTLE_DLY`, 2**26: clk cycles from the last transaction to capture arming.
- `MAX_RETRY`, 3: NACK retries per entry.
- `BYTES_PER_PIX`, 2: bytes per pixel, 1..4. `PIX_W = 8*BYTES_PER_PIX`.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_idx` out clog2(N_CFG): ROM index.
- `cfg_entry` in 16: {reg_addr, reg_data}, combinational from `cfg_idx`. The value 16'hFFFF terminates the table.
- `sccb_start` out 1: one-cycle pulse that begins a transaction.
- `sccb_stop` out 1: one-cycle pulse that ends a transaction.
- `sccb_wr_data` out 8: byte to send. Valid only when `sccb_start` is high or an ack is accepted.
- `sccb_ack` in 2: [1] pulses at the ack slot; [0] is 1 for ACK, 0 for NACK.
- `cmos_pclk`, `cmos_href`, `cmos_vsync` in 1: asynchronous camera pins.
- `cmos_d` in 8: camera data.
- `capture_en` in 1: allows new frames to start.
- `pix_full` in 1: downstream FIFO full.
- `pix_valid` out 1: one-cycle pulse, pixel present.
- `pix_data` out PIX_W: first byte received is placed in the MSBs.
- `pix_sof` out 1: asserted with the first `pix_valid` of a frame.
- `line_end` out 1: one-cycle pulse on the synced `href` falling edge during a frame.
- `frame_end` out 1: one-cycle pulse on the synced `vsync` rising edge during a frame.
- `frame_cnt` out 16: completed frames, wraps.
- `cfg_done` out 1: level; all table entries were written.
- `cfg_err` out 1: level, sticky; retries exhausted.
- `pix_ovf` out 1: level, sticky; a pixel was dropped.

## Operation
- Reset values: every output is 0. Internal state is BOOT, and all counters are 0.
- BOOT:
  - Delay counter runs to BOOT_DLY, then goes to FETCH.
- FETCH:
  - If `cfg_entry==16'hFFFF` or `cfg_idx==N_CFG`, go to SETTLE.
  - Otherwise go to START.
- START:
  - Pulse `sccb_start` with `sccb_wr_data=DEV_ADDR`, then go to ADDR.
- ADDR, DATA, STOPW (wait states):
  - Each waits for `sccb_ack[1]`.
  - On ACK (`sccb_ack==2'b11`), `sccb_wr_data` is driven in that same cycle: `reg_addr` in ADDR, `reg_data` in DATA, then the state advances.
  - In STOPW, ACK pulses `sccb_stop`, increments `cfg_idx`, clears the retry count and goes to GAP.
  - NACK (`2'b10`) in any wait state pulses `sccb_stop` and increments the retry count.
  - If the count exceeds MAX_RETRY, go to ERROR. Otherwise go to GAP and repeat the same entry.
- GAP:
  - Waits GAP_DLY, then goes to FETCH.
- SETTLE:
  - Waits SETTLE_DLY, sets `cfg_done`, then goes to ARM.
- ERROR:
  - Terminal state with `cfg_err=1`. Only reset leaves it. Capture never starts.
- ARM:
  - On the synced `vsync` falling edge with `capture_en=1`, go to FRAME.
  - Set an internal "first pixel" flag and clear the byte counter.
  - `capture_en` low at that edge skips the frame.
- FRAME:
  - On each synced `pclk` rising edge with synced `href=1`, shift in the synced byte and increment the byte counter.
  - On reaching BYTES_PER_PIX:
    - Reset the byte counter.
    - If `pix_full=0`, pulse `pix_valid` and drive `pix_sof` from the flag, then clear the flag.
    - If `pix_full=1`, drop the pixel and set `pix_ovf`. The flag is still cleared.
  - `href` falling edge: pulse `line_end` and discard any partial pixel.
  - `vsync` rising edge: pulse `frame_end`, increment `frame_cnt` and return to ARM.
- `capture_en` deasserted mid-frame does not abort the current frame.

## Timing
- Synchronisers:
  - `pclk`, `href` and `vsync` each pass through 2 flip-flops, then an edge-detect register.
  - `cmos_d` passes through 3 matching stages, so data stays aligned with the detected `pclk` edge.
  - Latency from pin edge to `pix_valid` is 3 clk after the last byte's `pclk` edge.
- Delays:
  - Measured from entering the wait state to leaving it.
  - Counters are wide enough for the largest delay parameter.
- Simultaneous edge cases:
  - `href` fall and pixel completion on the same cycle: the pixel is emitted first, then `line_end` pulses in the same cycle.
  - `vsync` rise during an `href`-high partial pixel: the partial pixel is discarded, and `frame_end` fires.
  - `sccb_ack` outside the wait states is ignored.
- Asynchronous reset mid-transaction aborts immediately. No `sccb_stop` is issued.

## Structure
- Package `cam_pkg`: state enum, table terminator 16'hFFFF, and the ack encodings ACK and NACK.
- Sub-module `cam_sync_edge`: 2-flop synchroniser plus rising/falling edge detect.
  - Instantiated three times: `pclk`, `href`, `vsync`.

## Test plan
- Boot and configuration:
  - Stimulus: BOOT_DLY=100, table {12_80, 12_04, FFFF}, ACK model.
  - Required response: 2 transactions with bytes 42,12,80 then 42,12,04. `cfg_done` rises after SETTLE; `cfg_idx=2`.
- Retry:
  - Stimulus: second byte NACKed once.
  - Required response: `sccb_stop`, GAP, then the same entry is resent. Total transactions = 3.
- Error:
  - Stimulus: all NACK, MAX_RETRY=3.
  - Required response: 4 attempts, then `cfg_err=1` with no further `sccb_start`.
- Capture:
  - Stimulus: BYTES_PER_PIX=2, one frame of 2 lines with 4 bytes/line (AA,BB,CC,DD).
  - Required response: `pix_data` AABB (`pix_sof=1`), then CCDD. `line_end` ×2, `frame_end` ×1, `frame_cnt=1`.
- Overflow and odd bytes:
  - Stimulus: `pix_full=1` for the second pixel; a line with 3 bytes.
  - Required response: `pix_ovf` is set. The partial pixel is discarded, and the next line starts aligned.
- Gating and reset:
  - Stimulus: `capture_en=0` at `vsync` fall, then reset mid-frame.
  - Required response: no pixels for the skipped frame. After reset all outputs are 0 and the block is in BOOT.
